// File: rtl/spi_reg_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_reg_bridge_pkg
//  Purpose  : Shared frame layout constants, FSM state encodings and a width
//             helper for the SPI-to-register bridge.
//  Contents : command field positions, 2-bit state encodings, cnt_width()
//  Revision : 1.0 - initial release
// ============================================================================
package spi_reg_bridge_pkg;

    // Command byte layout: {rw, reserved[3:0], addr[2:0]}
    localparam int c_cmd_bits = 8;
    localparam int c_rw_bit   = 7;
    localparam int c_rsvd_msb = 6;
    localparam int c_rsvd_lsb = 3;

    // FSM state encodings
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_cmd     = 2'd1;
    localparam logic [1:0] c_st_data    = 2'd2;
    localparam logic [1:0] c_st_wait_cs = 2'd3;

    // Bit counter width: one spare bit above the full frame length so the
    // saturating counter can never wrap within a frame.
    function automatic int cnt_width(input int data_bits);
        return $clog2(data_bits + c_cmd_bits) + 1;
    endfunction

endpackage : spi_reg_bridge_pkg
`default_nettype wire

// File: rtl/spi_reg_bridge_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : spi_reg_bridge_sync_edge
//  Purpose  : Multi-stage synchronizer for one asynchronous SPI pin plus
//             single-clk rise/fall pulse generation in the clk domain.
//  Ports    : clk, rst (async, active-high)
//             din   - asynchronous input pin
//             level - synchronized level (last synchronizer stage)
//             rise  - 1-clk pulse on a synchronized 0->1 change
//             fall  - 1-clk pulse on a synchronized 1->0 change
//  Revision : 1.0 - initial release
// ============================================================================
module spi_reg_bridge_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Reset to the pin's idle level so that no phantom edge appears when
    // reset is released with the bus idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], din};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level = r_sync[SYNC_STAGES-1];
    assign rise  =  level & ~r_prev;
    assign fall  = ~level &  r_prev;

endmodule : spi_reg_bridge_sync_edge
`default_nettype wire

// File: rtl/spi_reg_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : spi_reg_bridge
//  Purpose  : SPI mode-0 slave (MSB first) that decodes host frames of
//             {rw,4'b0000,addr[2:0]} + DATA_BITS data into a single-cycle
//             register write port and a combinational register read port.
//             All SPI pins are oversampled in the clk domain.
//  Ports    : clk, rst (async, active-high)
//             spi_sclk, spi_cs_n, spi_mosi - SPI inputs (async to clk)
//             spi_miso, spi_miso_oe        - SPI output and its enable
//             wr_en, wr_addr, wr_data      - 1-clk write strobe to regfile
//             rd_addr, rd_data             - read port to regfile
//             frame_err                    - 1-clk pulse, aborted/bad frame
//             busy                         - high while a frame is active
//  Revision : 1.0 - initial release
// ============================================================================
module spi_reg_bridge
    import spi_reg_bridge_pkg::*;
#(
    parameter int DATA_BITS   = 16,
    parameter int ADDR_BITS   = 3,
    parameter int NUM_REGS    = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_sclk,
    input  logic                 spi_cs_n,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [DATA_BITS-1:0] wr_data,
    output logic [ADDR_BITS-1:0] rd_addr,
    input  logic [DATA_BITS-1:0] rd_data,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int               c_cnt_w      = cnt_width(DATA_BITS);
    localparam logic [c_cnt_w-1:0] c_cmd_last   = c_cnt_w'(c_cmd_bits - 1);
    localparam logic [c_cnt_w-1:0] c_frame_last = c_cnt_w'(c_cmd_bits + DATA_BITS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max    = '1;

    // Synchronized pins and edge pulses
    logic w_sclk_level_unused, w_sclk_rise, w_sclk_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_reg_bridge_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(spi_sclk),
        .level(w_sclk_level_unused), .rise(w_sclk_rise), .fall(w_sclk_fall)
    );

    spi_reg_bridge_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .din(spi_cs_n),
        .level(w_cs_level), .rise(w_cs_rise), .fall(w_cs_fall)
    );

    spi_reg_bridge_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .din(spi_mosi),
        .level(w_mosi), .rise(w_mosi_rise_unused), .fall(w_mosi_fall_unused)
    );

    // State and datapath registers
    logic [1:0]           r_state, w_state_next;
    logic [c_cnt_w-1:0]   r_bit_cnt;
    logic [c_cmd_bits-2:0] r_cmd_shift;
    logic [DATA_BITS-2:0] r_rx_shift;     // MSB-1..0; final bit joins from w_mosi
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_active;
    logic                 r_rw;
    logic [ADDR_BITS-1:0] r_addr;
    logic                 r_rd_upd;
    logic                 r_rd_load;
    logic                 r_wr_en;
    logic [ADDR_BITS-1:0] r_wr_addr;
    logic [DATA_BITS-1:0] r_wr_data;
    logic [ADDR_BITS-1:0] r_rd_addr;
    logic                 r_frame_err;

    // Command byte as it stands once the current mosi bit is shifted in
    logic [c_cmd_bits-1:0] w_cmd;
    logic                  w_cmd_ok;
    logic                  w_abort, w_cmd_end, w_data_end;

    assign w_cmd    = {r_cmd_shift, w_mosi};
    assign w_cmd_ok = (w_cmd[c_rsvd_msb:c_rsvd_lsb] == '0) &&
                      (int'(w_cmd[ADDR_BITS-1:0]) < NUM_REGS);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_next;
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        w_cmd_end    = 1'b0;
        w_data_end   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_cs_fall) w_state_next = c_st_cmd;
            end
            c_st_cmd: begin
                if (w_cs_rise) begin
                    w_abort      = 1'b1;
                    w_state_next = c_st_idle;
                end else if (w_sclk_rise && (r_bit_cnt == c_cmd_last)) begin
                    w_cmd_end    = 1'b1;
                    w_state_next = w_cmd_ok ? c_st_data : c_st_wait_cs;
                end
            end
            c_st_data: begin
                // A final data rise landing with the CS release still
                // completes the frame; the release is consumed here.
                if (w_sclk_rise && (r_bit_cnt == c_frame_last)) begin
                    w_data_end   = 1'b1;
                    w_state_next = w_cs_rise ? c_st_idle : c_st_wait_cs;
                end else if (w_cs_rise) begin
                    w_abort      = 1'b1;
                    w_state_next = c_st_idle;
                end
            end
            c_st_wait_cs: begin
                if (w_cs_rise) w_state_next = c_st_idle;
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_cmd_shift <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_tx_active <= 1'b0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_rd_upd    <= 1'b0;
            r_rd_load   <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rd_addr   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_en     <= 1'b0;
            r_rd_load   <= 1'b0;
            r_rd_upd    <= w_cmd_end;
            r_frame_err <= w_abort | (w_cmd_end & ~w_cmd_ok);

            if ((r_state == c_st_idle) && w_cs_fall) begin
                r_bit_cnt   <= '0;
                r_cmd_shift <= '0;
                r_rx_shift  <= '0;
                r_tx_shift  <= '0;
                r_tx_active <= 1'b0;
            end

            if (w_abort) begin
                r_bit_cnt   <= '0;
                r_rx_shift  <= '0;
                r_tx_shift  <= '0;
                r_tx_active <= 1'b0;
            end else begin
                if (w_sclk_rise && ((r_state == c_st_cmd) || (r_state == c_st_data)) &&
                    (r_bit_cnt != c_cnt_max))
                    r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);

                if ((r_state == c_st_cmd) && w_sclk_rise)
                    r_cmd_shift <= w_cmd[c_cmd_bits-2:0];

                if (w_cmd_end) begin
                    r_rw   <= w_cmd[c_rw_bit];
                    r_addr <= w_cmd[ADDR_BITS-1:0];
                end

                // rd_addr follows the command by one clk; the regfile read
                // data is captured one clk after that.
                if (r_rd_upd) begin
                    r_rd_addr <= r_addr;
                    r_rd_load <= r_rw && (r_state == c_st_data);
                end

                if (r_rd_load && (r_state == c_st_data))
                    r_tx_shift <= rd_data;

                if ((r_state == c_st_data) && !r_rw && w_sclk_rise)
                    r_rx_shift <= {r_rx_shift[DATA_BITS-3:0], w_mosi};

                if (w_data_end && !r_rw) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_addr;
                    r_wr_data <= {r_rx_shift, w_mosi};
                end

                // First fall of the data phase exposes the MSB; later falls shift.
                if ((r_state == c_st_data) && r_rw && w_sclk_fall) begin
                    if (!r_tx_active) r_tx_active <= 1'b1;
                    else              r_tx_shift  <= {r_tx_shift[DATA_BITS-2:0], 1'b0};
                end
            end
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        busy        = (r_state != c_st_idle);
        spi_miso_oe = ~w_cs_level;
        spi_miso    = (r_state == c_st_data) & r_rw & r_tx_active & r_tx_shift[DATA_BITS-1];
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign rd_addr   = r_rd_addr;
    assign frame_err = r_frame_err;

endmodule : spi_reg_bridge
`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_reg_bridge
//  Purpose  : Self-checking bench for spi_reg_bridge with a behavioural
//             six-entry register file as load and a frame-level reference
//             model of expected register contents, strobes and read data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_bridge;

    localparam int HALF = 100;   // SCLK 5 MHz

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe, wr_en, frame_err, busy;
    logic [2:0]  wr_addr, rd_addr;
    logic [15:0] wr_data, rd_data;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int err_cnt  = 0;
    logic [2:0]  last_wa = '0;
    logic [15:0] last_wd = '0;

    logic [15:0] regs     [6];
    logic [15:0] exp_regs [6];

    always #5 clk = ~clk;

    spi_reg_bridge #(
        .DATA_BITS(16), .ADDR_BITS(3), .NUM_REGS(6), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_err(frame_err), .busy(busy)
    );

    // Register file load: synchronous write, combinational read
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 6; k++) regs[k] <= '0;
        end else if (wr_en && (wr_addr < 3'd6)) begin
            regs[wr_addr] <= wr_data;
        end
    end
    assign rd_data = (rd_addr < 3'd6) ? regs[rd_addr] : 16'h0000;

    // Strobe monitors, sampled away from the active edge
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt  <= wr_cnt + 1;
            last_wa <= wr_addr;
            last_wd <= wr_data;
        end
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One host frame: nbits total clocks (cmd + data + extras), then CS release.
    // rst_bit >= 0 pulses rst just before that bit's rising edge.
    task automatic run_frame(input logic [7:0] cmd, input logic [15:0] data,
                             input int nbits, input int gap_ns, input int rst_bit);
        logic [23:0] word;
        logic [15:0] rx_bits;
        logic [15:0] exp_rd;
        logic        miso_any, valid, is_read, full, did_rst, exp_wr, exp_err;
        int          wr0, err0;

        word     = {cmd, data};
        rx_bits  = '0;
        miso_any = 1'b0;
        did_rst  = 1'b0;
        wr0      = wr_cnt;
        err0     = err_cnt;
        valid    = (cmd[6:3] == 4'b0000) && (cmd[2:0] < 3'd6);
        is_read  = cmd[7];
        full     = (nbits >= 24);
        exp_rd   = valid ? exp_regs[cmd[2:0]] : 16'h0000;

        spi_cs_n = 1'b0;
        spi_mosi = word[23];
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                #20;
                rst = 1'b1;
                #30;
                check("rst_mid_outputs",
                      32'({spi_miso, spi_miso_oe, wr_en, frame_err, busy, wr_addr, wr_data, rd_addr}), 32'd0);
                spi_cs_n = 1'b1;
                #30;
                rst = 1'b0;
                for (int k = 0; k < 6; k++) exp_regs[k] = 16'h0000;
                did_rst = 1'b1;
                break;
            end
            if (i > 0) spi_mosi = (i < 24) ? word[23-i] : 1'($urandom);
            #HALF;
            if (i >= 8 && i < 24) rx_bits = {rx_bits[14:0], spi_miso};
            miso_any = miso_any | spi_miso;
            if (i == 4) begin
                check("mid_oe", 32'(spi_miso_oe), 32'd1);
                check("mid_busy", 32'(busy), 32'd1);
            end
            spi_sclk = 1'b1;
            #HALF;
            spi_sclk = 1'b0;
        end
        #HALF;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        #gap_ns;

        exp_wr  = !did_rst && valid && full && !is_read;
        exp_err = !did_rst && (!valid || !full);
        if (exp_wr) exp_regs[cmd[2:0]] = data;

        check("wr_count", 32'(wr_cnt - wr0), 32'(exp_wr));
        check("err_count", 32'(err_cnt - err0), 32'(exp_err));
        check("busy_after", 32'(busy), 32'd0);
        check("oe_after", 32'(spi_miso_oe), 32'd0);
        if (exp_wr) begin
            check("wr_addr", 32'(last_wa), 32'(cmd[2:0]));
            check("wr_data", 32'(last_wd), 32'(data));
        end
        if (is_read && valid && full && !did_rst)
            check("miso_data", 32'(rx_bits), 32'(exp_rd));
        else if (!is_read || !valid)
            check("miso_quiet", 32'(miso_any), 32'd0);
        for (int k = 0; k < 6; k++)
            check($sformatf("reg%0d", k), 32'(regs[k]), 32'(exp_regs[k]));
    endtask

    initial begin
        logic [2:0]  a;
        logic        rw;
        logic [15:0] d;

        for (int k = 0; k < 6; k++) exp_regs[k] = 16'h0000;

        // Reset state
        repeat (4) @(negedge clk);
        check("reset_outputs",
              32'({spi_miso, spi_miso_oe, wr_en, frame_err, busy, wr_addr, wr_data, rd_addr}), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_oe", 32'(spi_miso_oe), 32'd0);

        // Basic write then read-back
        run_frame(8'h02, 16'h1234, 24, 400, -1);
        run_frame(8'h82, 16'h0000, 24, 400, -1);

        // Invalid address and reserved bits set
        run_frame(8'h07, 16'hBEEF, 24, 400, -1);
        run_frame(8'h0A, 16'hBEEF, 24, 400, -1);

        // Abort after 12 bits, then a good frame to the same register
        run_frame(8'h01, 16'h5A5A, 12, 400, -1);
        run_frame(8'h01, 16'h00FF, 24, 400, -1);

        // Extra SCLK cycles after the data field
        run_frame(8'h04, 16'hA5A5, 29, 400, -1);
        run_frame(8'h84, 16'h0000, 24, 400, -1);

        // Back-to-back frames with one SCLK period gap
        run_frame(8'h03, 16'($urandom), 24, 2 * HALF, -1);
        run_frame(8'h05, 16'($urandom), 24, 2 * HALF, -1);
        run_frame(8'h83, 16'h0000, 24, 400, -1);

        // Randomized valid frames
        for (int n = 0; n < 10; n++) begin
            a  = 3'($urandom_range(0, 5));
            rw = 1'($urandom_range(0, 1));
            d  = 16'($urandom);
            run_frame({rw, 4'b0000, a}, d, 24, 400, -1);
        end

        // Reset in the middle of a write, then read addr 0
        run_frame(8'h00, 16'hCAFE, 24, 400, 15);
        run_frame(8'h80, 16'h0000, 24, 400, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_spi_reg_bridge
`default_nettype wire
